tilemap_index_responder: RTL and testbench
==========================================

Name: tilemap_index_responder

Overview:
- Responder end of the tilemap index RAM interface. It owns the 8-bit tile-index memory.
- Port A serves the tilemap renderer's read addresses and its control-machine writes (scroll/clear), sharing one address bus.
- Port B serves CPU byte reads/writes through a small request queue, with hazard ordering against port-A writes.
- Sits between the tilemap renderer and the CPU bus decoder.

Parameters:
- RAM_WIDTH, 10, index address width; memory depth = 2^RAM_WIDTH bytes.
- FIFO_DEPTH, 4, CPU request queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- vid_addr  in  RAM_WIDTH  port-A address, shared by renderer reads and control writes
- ctl_wr  in  1  port-A write strobe
- ctl_data_in  in  8  port-A write data
- vid_data_out  out  8  port-A registered read data
- cpu_hold  in  1  high while the tilemap control machine is busy; freezes CPU service
- cpu_req  in  1  CPU request valid
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  RAM_WIDTH  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_ready  out  1  queue can accept a request this cycle
- cpu_rdata  out  8  CPU read data
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid

Behaviour:
- Memory contents are not reset; clearing is the control machine's job.
- Reset values: vid_data_out=0, cpu_rdata=0, cpu_rvalid=0, queue empty. cpu_ready=0 while reset is high and 1 on the first cycle after.
- Port A, every cycle:
  - vid_data_out <= mem[vid_addr], read-first. If ctl_wr hits the same address in that cycle, the old byte is returned.
  - If ctl_wr, mem[vid_addr] <= ctl_data_in.
  - Read latency is exactly 1 cycle, with no stall.
- CPU queue:
  - FIFO of {we, addr, wdata}, FIFO_DEPTH entries, with a registered count.
  - cpu_ready = !full && !reset. Full is decided on the registered count, so no push is accepted while full even if a pop occurs in the same cycle.
  - A push occurs on cpu_req && cpu_ready.
  - Push and pop in the same cycle leave the count unchanged.
- Service FSM, states IDLE, ISSUE, STALL:
  - IDLE -> ISSUE when the queue is non-empty and cpu_hold=0.
  - ISSUE performs the head access and pops it.
    - Write: mem[addr] <= wdata.
    - Read: cpu_rdata <= mem[addr]; cpu_rvalid=1 on the following cycle.
    - ISSUE stays in ISSUE if another entry is pending, giving 1 access per cycle back to back. Otherwise it returns to IDLE.
  - Hazard: the head addr equals vid_addr and ctl_wr=1 in the same cycle -> STALL, no pop.
    - STALL lasts at least 1 cycle, then re-evaluates.
    - Net effect: the control write lands first, a CPU write lands after it and persists, and a CPU read returns the control-written value.
  - cpu_hold=1 in any state -> no pop; enter or remain in IDLE. The head is retained.
- Ordering: CPU requests complete in acceptance order. A read issued after a write to the same address returns the written data.
- Address widths: all addresses are RAM_WIDTH bits with no wrap arithmetic. The FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- Reset mid-operation: queued entries are discarded, and no cpu_rvalid is issued for a read that was in flight. Memory is unaffected except for a write committed in the reset cycle's preceding edge.

Optional Feature:
- Macro TM_INDEX_STATS_EN.
- With it defined: adds outputs stat_cpu_writes[15:0], stat_ctl_writes[15:0] and stat_stalls[15:0].
  - These are saturating counters (hold at 16'hFFFF), cleared by reset.
  - They count CPU writes committed, ctl_wr cycles, and STALL cycles.
- Without it: the ports and logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package tilemap_pkg:
  - service FSM state encoding (IDLE=0, ISSUE=1, STALL=2);
  - request-record typedef {we, addr, wdata};
  - default RAM_WIDTH.
- One sub-module, tilemap_req_fifo: synchronous FIFO with push/pop, full/empty and a registered count. The FSM, hazard compare and dual-port memory stay in the top module.

Test Plan:
- Port-A read: write 8'h5A at 10'h123 via ctl_wr. Drive vid_addr=10'h123 on the next cycle -> vid_data_out=8'h5A one cycle later. A same-cycle write+read returns the previous value.
- CPU write/read: push write 10'h020=8'hC3, then read 10'h020 back to back -> cpu_rvalid pulses once with cpu_rdata=8'hC3, and cpu_ready stays 1 throughout.
- Queue full: hold cpu_hold=1 and push 4 requests -> cpu_ready=0 on the 5th. The 5th request is not accepted. Release cpu_hold -> 4 accesses complete on consecutive cycles.
- Hazard: CPU write 10'h040=8'h11 at the head while ctl_wr writes 10'h040=8'h22 -> one STALL cycle; the final mem[10'h040] is 8'h11. A CPU read in the same situation returns 8'h22.
- Reset mid-queue: 3 requests pending, including a read, and assert reset for 1 cycle -> queue empty, no cpu_rvalid, cpu_ready=1 on the next cycle, and earlier committed data intact.
- With TM_INDEX_STATS_EN: 2 CPU writes, 3 ctl writes and 1 stall -> counters read 2/3/1, and reset clears them to 0.

Source files
------------

// File: rtl/tilemap_pkg.sv
// Shared types for the tilemap index responder: service FSM encoding and the
// CPU request record layout at the default index address width.
package tilemap_pkg;

   localparam int DEF_RAM_WIDTH = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      STALL = 2'd2
   } svc_state_t;

   typedef struct packed {
      logic                     we;
      logic [DEF_RAM_WIDTH-1:0] addr;
      logic [7:0]               wdata;
   } tm_req_t;

endpackage

// File: rtl/tilemap_req_fifo.sv
// Synchronous request FIFO with registered occupancy count. Full/empty derive
// from the registered count only, so a same-cycle pop never frees a slot early.
module tilemap_req_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 19
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [W-1:0]  store [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = store[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push)
         store[wr_ptr] <= din;
   end

   // Pointers are exactly log2(DEPTH) bits and wrap on their own.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tilemap_index_responder.sv
// Tile-index RAM responder: port A for renderer reads / control writes, port B
// for queued CPU accesses. Optional stats counters under TM_INDEX_STATS_EN.
module tilemap_index_responder
   import tilemap_pkg::*;
#(
   parameter int RAM_WIDTH  = DEF_RAM_WIDTH,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [RAM_WIDTH-1:0] vid_addr,
   input  logic                 ctl_wr,
   input  logic [7:0]           ctl_data_in,
   output logic [7:0]           vid_data_out,
   input  logic                 cpu_hold,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [RAM_WIDTH-1:0] cpu_addr,
   input  logic [7:0]           cpu_wdata,
   output logic                 cpu_ready,
   output logic [7:0]           cpu_rdata,
`ifdef TM_INDEX_STATS_EN
   output logic [15:0]          stat_cpu_writes,
   output logic [15:0]          stat_ctl_writes,
   output logic [15:0]          stat_stalls,
`endif
   output logic                 cpu_rvalid
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic                 we;
      logic [RAM_WIDTH-1:0] addr;
      logic [7:0]           wdata;
   } req_t;

   logic [7:0] mem [2**RAM_WIDTH];

   req_t          push_req;
   req_t          head;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          push;
   logic          hazard;
   logic          cpu_access;
   logic          cpu_wr_commit;
   logic          cpu_rd_issue;
   logic          ctl_commit;
   svc_state_t    state;
   svc_state_t    state_nx;

   assign cpu_ready     = !fifo_full && !reset;
   assign push          = cpu_req && cpu_ready;
   assign push_req      = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
   assign ctl_commit    = ctl_wr && !reset;
   assign hazard        = ctl_wr && (head.addr == vid_addr);
   assign cpu_wr_commit = cpu_access && head.we;
   assign cpu_rd_issue  = cpu_access && !head.we;

   tilemap_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     ($bits(req_t))
   ) u_req_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (cpu_access),
      .din   (push_req),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // A head colliding with a same-cycle control write waits in STALL so the
   // control byte lands first; the CPU access then replays on top of it.
   always_comb begin
      state_nx   = state;
      cpu_access = 1'b0;
      if (reset || cpu_hold) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty)
                  state_nx = ISSUE;
            end
            ISSUE: begin
               if (fifo_empty) begin
                  state_nx = IDLE;
               end else if (hazard) begin
                  state_nx = STALL;
               end else begin
                  cpu_access = 1'b1;
                  state_nx   = (fifo_count > CW'(1) || push) ? ISSUE : IDLE;
               end
            end
            STALL: begin
               state_nx = fifo_empty ? IDLE : ISSUE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // Contents are never reset; the hazard FSM keeps the two writes disjoint.
   always_ff @(posedge clk) begin
      if (ctl_commit)
         mem[vid_addr] <= ctl_data_in;
      if (cpu_wr_commit)
         mem[head.addr] <= head.wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         vid_data_out <= '0;
         cpu_rdata    <= '0;
         cpu_rvalid   <= 1'b0;
      end else begin
         state        <= state_nx;
         vid_data_out <= mem[vid_addr];
         cpu_rvalid   <= cpu_rd_issue;
         if (cpu_rd_issue)
            cpu_rdata <= mem[head.addr];
      end
   end

`ifdef TM_INDEX_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_cpu_writes <= '0;
         stat_ctl_writes <= '0;
         stat_stalls     <= '0;
      end else begin
         if (cpu_wr_commit && stat_cpu_writes != 16'hFFFF)
            stat_cpu_writes <= stat_cpu_writes + 16'd1;
         if (ctl_wr && stat_ctl_writes != 16'hFFFF)
            stat_ctl_writes <= stat_ctl_writes + 16'd1;
         if (state == STALL && stat_stalls != 16'hFFFF)
            stat_stalls <= stat_stalls + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tilemap_index_responder.sv
// Scoreboard bench for tilemap_index_responder: stimulus queues expected read
// data, a monitor pops and compares on every cpu_rvalid.
module tb_tilemap_index_responder;
   import tilemap_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] vid_addr = '0;
   logic       ctl_wr = 1'b0;
   logic [7:0] ctl_data_in = '0;
   logic [7:0] vid_data_out;
   logic       cpu_hold = 1'b0;
   logic       cpu_req = 1'b0;
   logic       cpu_we = 1'b0;
   logic [9:0] cpu_addr = '0;
   logic [7:0] cpu_wdata = '0;
   logic       cpu_ready;
   logic [7:0] cpu_rdata;
   logic       cpu_rvalid;
`ifdef TM_INDEX_STATS_EN
   logic [15:0] stat_cpu_writes;
   logic [15:0] stat_ctl_writes;
   logic [15:0] stat_stalls;
`endif

   tilemap_index_responder #(.RAM_WIDTH(10), .FIFO_DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .vid_addr     (vid_addr),
      .ctl_wr       (ctl_wr),
      .ctl_data_in  (ctl_data_in),
      .vid_data_out (vid_data_out),
      .cpu_hold     (cpu_hold),
      .cpu_req      (cpu_req),
      .cpu_we       (cpu_we),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_ready    (cpu_ready),
      .cpu_rdata    (cpu_rdata),
`ifdef TM_INDEX_STATS_EN
      .stat_cpu_writes (stat_cpu_writes),
      .stat_ctl_writes (stat_ctl_writes),
      .stat_stalls     (stat_stalls),
`endif
      .cpu_rvalid   (cpu_rvalid)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          cyc_cnt = 0;
   logic [7:0]  exp_q[$];
   int          rv_cyc[$];

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic tm_req_t mk(input logic we, input logic [9:0] a, input logic [7:0] d);
      tm_req_t r;
      r.we = we;
      r.addr = a;
      r.wdata = d;
      return r;
   endfunction

   // Monitor: every read response must match the oldest outstanding expectation.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (cpu_rvalid) begin
            rv_cyc.push_back(cyc_cnt);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rvalid_unexpected: got rdata %0h want no response", cpu_rdata);
            end else begin
               chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, exp_q.pop_front()});
            end
         end
      end
   end

   task automatic ctl_write(input logic [9:0] a, input logic [7:0] d);
      ctl_wr = 1'b1;
      vid_addr = a;
      ctl_data_in = d;
      @(negedge clk);
      ctl_wr = 1'b0;
   endtask

   task automatic vid_read(input logic [9:0] a, input logic [7:0] exp, input string name);
      vid_addr = a;
      @(negedge clk);
      chk(name, {24'd0, vid_data_out}, {24'd0, exp});
   endtask

   task automatic push(input tm_req_t r, input logic [7:0] exp);
      int n = 0;
      while (!cpu_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("push_ready", {31'd0, cpu_ready}, 32'd1);
      cpu_req = 1'b1;
      cpu_we = r.we;
      cpu_addr = r.addr;
      cpu_wdata = r.wdata;
      if (!r.we)
         exp_q.push_back(exp);
      @(negedge clk);
      cpu_req = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size(), 32'd0);
   endtask

   // Head parked by cpu_hold, released, then hit by a control write in its ISSUE cycle.
   task automatic hazard_case(input tm_req_t r, input logic [7:0] ctl_d, input logic [7:0] exp);
      cpu_hold = 1'b1;
      push(r, exp);
      cpu_hold = 1'b0;
      @(negedge clk);
      ctl_write(r.addr, ctl_d);
      drain();
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int base;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
      chk("rst_vid", {24'd0, vid_data_out}, 32'd0);
      chk("rst_rdata", {24'd0, cpu_rdata}, 32'd0);
      chk("rst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_ready", {31'd0, cpu_ready}, 32'd1);
      @(negedge clk);

      // Port A read latency and read-first behaviour
      ctl_write(10'h124, 8'h3C);
      vid_read(10'h124, 8'h3C, "pa_read_124");
      ctl_write(10'h123, 8'h5A);
      vid_read(10'h123, 8'h5A, "pa_read_123");
      vid_read(10'h124, 8'h3C, "pa_reread_124");
      ctl_wr = 1'b1;
      vid_addr = 10'h123;
      ctl_data_in = 8'hA5;
      @(negedge clk);
      ctl_wr = 1'b0;
      chk("pa_read_first", {24'd0, vid_data_out}, 32'h5A);
      @(negedge clk);
      chk("pa_new_value", {24'd0, vid_data_out}, 32'hA5);

      // CPU write then read back to back
      base = rv_cyc.size();
      push(mk(1'b1, 10'h020, 8'hC3), 8'h00);
      push(mk(1'b0, 10'h020, 8'h00), 8'hC3);
      drain();
      repeat (3) @(negedge clk);
      chk("t2_rvalid_count", rv_cyc.size() - base, 32'd1);

      // Queue full under hold, then back-to-back drain
      for (int i = 0; i < 4; i++)
         ctl_write(10'h200 + 10'(i), 8'h10 + 8'(i));
      cpu_hold = 1'b1;
      for (int i = 0; i < 4; i++)
         push(mk(1'b0, 10'h200 + 10'(i), 8'h00), 8'h10 + 8'(i));
      chk("t3_full_ready", {31'd0, cpu_ready}, 32'd0);
      cpu_req = 1'b1;
      cpu_we = 1'b0;
      cpu_addr = 10'h204;
      @(negedge clk);
      cpu_req = 1'b0;
      rv_cyc.delete();
      cpu_hold = 1'b0;
      drain();
      repeat (5) @(negedge clk);
      chk("t3_rvalid_count", rv_cyc.size(), 32'd4);
      if (rv_cyc.size() == 4)
         for (int i = 1; i < 4; i++)
            chk("t3_consecutive", rv_cyc[i] - rv_cyc[i-1], 32'd1);
      chk("t3_ready_again", {31'd0, cpu_ready}, 32'd1);

      // Hazard against a same-cycle control write
      hazard_case(mk(1'b1, 10'h040, 8'h11), 8'h22, 8'h00);
      vid_read(10'h040, 8'h11, "hz_write_final");
      hazard_case(mk(1'b0, 10'h040, 8'h00), 8'h22, 8'h22);
      vid_read(10'h040, 8'h22, "hz_read_final");

      // Reset with requests pending
      ctl_write(10'h301, 8'hEE);
      ctl_write(10'h302, 8'hEF);
      push(mk(1'b1, 10'h300, 8'h77), 8'h00);
      repeat (5) @(negedge clk);
      cpu_hold = 1'b1;
      push(mk(1'b1, 10'h301, 8'h01), 8'h00);
      push(mk(1'b0, 10'h300, 8'h00), 8'h77);
      push(mk(1'b1, 10'h302, 8'h02), 8'h00);
      reset = 1'b1;
      #1;
      chk("rst_mid_ready", {31'd0, cpu_ready}, 32'd0);
      @(negedge clk);
      exp_q.delete();
      reset = 1'b0;
      cpu_hold = 1'b0;
      #1;
      chk("rst_mid_ready_after", {31'd0, cpu_ready}, 32'd1);
      chk("rst_mid_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      repeat (6) @(negedge clk);
      vid_read(10'h300, 8'h77, "rst_kept_300");
      vid_read(10'h301, 8'hEE, "rst_drop_301");
      vid_read(10'h302, 8'hEF, "rst_drop_302");
      cpu_hold = 1'b1;
      for (int i = 0; i < 4; i++)
         push(mk(1'b0, 10'h300, 8'h00), 8'h77);
      chk("rst_queue_cap", {31'd0, cpu_ready}, 32'd0);
      cpu_hold = 1'b0;
      drain();

`ifdef TM_INDEX_STATS_EN
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("stat_cpu_zero", {16'd0, stat_cpu_writes}, 32'd0);
      chk("stat_ctl_zero", {16'd0, stat_ctl_writes}, 32'd0);
      chk("stat_stall_zero", {16'd0, stat_stalls}, 32'd0);
      hazard_case(mk(1'b1, 10'h050, 8'h01), 8'h02, 8'h00);
      push(mk(1'b1, 10'h051, 8'h02), 8'h00);
      repeat (4) @(negedge clk);
      ctl_write(10'h052, 8'h00);
      ctl_write(10'h053, 8'h00);
      @(negedge clk);
      chk("stat_cpu_writes", {16'd0, stat_cpu_writes}, 32'd2);
      chk("stat_ctl_writes", {16'd0, stat_ctl_writes}, 32'd3);
      chk("stat_stalls", {16'd0, stat_stalls}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("stat_cpu_clr", {16'd0, stat_cpu_writes}, 32'd0);
      chk("stat_ctl_clr", {16'd0, stat_ctl_writes}, 32'd0);
      chk("stat_stall_clr", {16'd0, stat_stalls}, 32'd0);
`endif

      repeat (3) @(negedge clk);
      chk("final_queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
